// File: rtl/gemm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gemm_pkg
//  Brief    : Shared types and elaboration helpers for the GEMM write-back path
//  Revision : 1.0 - initial release
// ============================================================================
package gemm_pkg;

    // Packer FSM encoding
    localparam logic [0:0] C_ST_IDLE = 1'b0;
    localparam logic [0:0] C_ST_SEND = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE = C_ST_IDLE,
        ST_SEND = C_ST_SEND
    } pk_state_e;

    // Number of output beats needed to carry one accumulator row
    function automatic int calc_beats(input int lanes, input int acc_w, input int axi_w);
        return (lanes * acc_w) / axi_w;
    endfunction

    // Number of accumulator lanes packed into one output beat
    function automatic int calc_lpb(input int acc_w, input int axi_w);
        return axi_w / acc_w;
    endfunction

    // Counter width for a modulus, never narrower than one bit
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/row_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : row_fifo
//  Brief    : Power-of-two deep row buffer with registered occupancy count;
//             head entry is presented combinationally
//  Revision : 1.0 - initial release
// ============================================================================
module row_fifo
    import gemm_pkg::*;
#(
    parameter int WIDTH = 512,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           push_data,
    output logic [WIDTH-1:0]           head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = clog2_min1(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
            $error("row_fifo: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Storage: data only, no reset needed since occupancy gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; push while full is only legal alongside a pop
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_data = r_mem[r_rd_ptr];
    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;

endmodule
`default_nettype wire

// File: rtl/acc_wb_packer.sv
`default_nettype none
// ============================================================================
//  Module   : acc_wb_packer
//  Brief    : Buffers de-skewed accumulator rows and serialises each row into
//             AXI-width beats with tile framing, overflow and status flags
//  Revision : 1.0 - initial release
// ============================================================================
module acc_wb_packer
    import gemm_pkg::*;
#(
    parameter int SYS_ARRAY_WIDTH  = 16,
    parameter int SYS_ARRAY_HEIGHT = 16,
    parameter int ACC_WIDTH        = 32,
    parameter int AXI_DATA_WIDTH   = 128,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 row_valid,
    input  logic [SYS_ARRAY_WIDTH*ACC_WIDTH-1:0] row_data,
    input  logic                                 err_clear,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [AXI_DATA_WIDTH-1:0]            m_data,
    output logic                                 m_last,
    output logic                                 fifo_full,
    output logic                                 overflow,
    output logic                                 tile_done,
    output logic                                 busy
);

    localparam int ROW_W  = SYS_ARRAY_WIDTH * ACC_WIDTH;
    localparam int BEATS  = calc_beats(SYS_ARRAY_WIDTH, ACC_WIDTH, AXI_DATA_WIDTH);
    localparam int LPB    = calc_lpb(ACC_WIDTH, AXI_DATA_WIDTH);
    localparam int BEAT_W = clog2_min1(BEATS);
    localparam int ROWC_W = clog2_min1(SYS_ARRAY_HEIGHT);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    generate
        if (((ROW_W % AXI_DATA_WIDTH) != 0) || ((AXI_DATA_WIDTH % ACC_WIDTH) != 0)) begin : g_width_check
            $error("acc_wb_packer: row and beat widths must divide exactly");
        end
    endgenerate

    pk_state_e                 r_state;
    logic [BEAT_W-1:0]         r_beat_cnt;
    logic [ROWC_W-1:0]         r_row_cnt;
    logic                      r_overflow;
    logic                      r_tile_done;

    logic [ROW_W-1:0]          w_head;
    logic                      w_full;
    logic                      w_empty;
    logic [CNT_W-1:0]          w_count;
    logic                      w_valid;
    logic                      w_hs;
    logic                      w_last_beat;
    logic                      w_pop;
    logic                      w_push;
    logic                      w_drop;
    logic                      w_more;
    logic                      w_last;
    logic [AXI_DATA_WIDTH-1:0] w_beats [BEATS];

    row_fifo #(
        .WIDTH (ROW_W),
        .DEPTH (FIFO_DEPTH)
    ) u_row_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (row_data),
        .head_data (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    // Beat k of the head row holds lanes k*LPB .. k*LPB+LPB-1, lowest lane in LSBs
    generate
        for (genvar k = 0; k < BEATS; k++) begin : g_beat_slice
            assign w_beats[k] = w_head[k*LPB*ACC_WIDTH +: AXI_DATA_WIDTH];
        end
    endgenerate

    // SEND is entered exactly when the FIFO becomes non-empty, so it mirrors occupancy
    assign w_valid     = (r_state == ST_SEND);
    assign w_hs        = w_valid & m_ready;
    assign w_last_beat = (r_beat_cnt == BEAT_W'(BEATS - 1));
    assign w_pop       = w_hs & w_last_beat;
    assign w_push      = row_valid & (~w_full | w_pop);
    assign w_drop      = row_valid & w_full & ~w_pop;
    assign w_more      = (w_count != CNT_W'(1)) | w_push;
    assign w_last      = w_valid & w_last_beat & (r_row_cnt == ROWC_W'(SYS_ARRAY_HEIGHT - 1));

    // FSM and beat counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_beat_cnt <= '0;
                    if (w_push) r_state <= ST_SEND;
                end
                ST_SEND: begin
                    if (w_hs) begin
                        if (w_last_beat) begin
                            r_beat_cnt <= '0;
                            if (!w_more) r_state <= ST_IDLE;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_beat_cnt <= '0;
                end
            endcase
        end
    end

    // Row-within-tile counter, advanced on each completed row
    always_ff @(posedge clk) begin
        if (reset) begin
            r_row_cnt <= '0;
        end else if (w_pop) begin
            if (r_row_cnt == ROWC_W'(SYS_ARRAY_HEIGHT - 1)) r_row_cnt <= '0;
            else                                            r_row_cnt <= r_row_cnt + 1'b1;
        end
    end

    // Sticky overflow (a drop beats a simultaneous clear) and tile completion pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_tile_done <= 1'b0;
        end else begin
            if (w_drop)         r_overflow <= 1'b1;
            else if (err_clear) r_overflow <= 1'b0;
            r_tile_done <= w_hs & w_last;
        end
    end

    assign m_valid   = w_valid;
    assign m_data    = w_valid ? w_beats[r_beat_cnt] : '0;
    assign m_last    = w_last;
    assign fifo_full = w_full;
    assign overflow  = r_overflow;
    assign tile_done = r_tile_done;
    assign busy      = ~w_empty | w_valid;

endmodule
`default_nettype wire

// File: tb/tb_acc_wb_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_acc_wb_packer
//  Brief    : Self-checking bench for acc_wb_packer (default parameters)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_acc_wb_packer;

    localparam int W      = 16;
    localparam int H      = 16;
    localparam int ACC    = 32;
    localparam int AXI    = 128;
    localparam int DEPTH  = 4;
    localparam int BEATS  = 4;
    localparam int ROW_W  = W * ACC;

    typedef struct packed {
        logic [AXI-1:0] data;
        logic           last;
    } beat_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             row_valid = 1'b0;
    logic [ROW_W-1:0] row_data = '0;
    logic             err_clear = 1'b0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [AXI-1:0]   m_data;
    logic             m_last;
    logic             fifo_full;
    logic             overflow;
    logic             tile_done;
    logic             busy;

    int tests = 0;
    int fails = 0;

    // scoreboard / reference state
    beat_t          sb [$];
    int             row_idx = 0;
    logic           exp_ovf = 1'b0;
    logic           exp_td  = 1'b0;
    logic           prev_stall = 1'b0;
    logic [AXI-1:0] prev_data = '0;
    bit             mon_en = 1'b0;
    int             beats_seen = 0;
    int             lasts_seen = 0;
    int             m_occ;
    bit             m_pop;
    bit             m_hs;
    beat_t          m_e;

    acc_wb_packer #(
        .SYS_ARRAY_WIDTH  (W),
        .SYS_ARRAY_HEIGHT (H),
        .ACC_WIDTH        (ACC),
        .AXI_DATA_WIDTH   (AXI),
        .FIFO_DEPTH       (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row_valid (row_valid),
        .row_data  (row_data),
        .err_clear (err_clear),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .fifo_full (fifo_full),
        .overflow  (overflow),
        .tile_done (tile_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model: compares every cycle, then applies the upcoming edge
    always @(negedge clk) begin
        if (mon_en) begin
            m_occ = (sb.size() + BEATS - 1) / BEATS;
            m_pop = 1'b0;
            tests++;
            if (m_valid !== (sb.size() > 0)) begin
                fails++;
                $display("FAIL mon_valid t=%0t: m_valid=%b expected=%b", $time, m_valid, sb.size() > 0);
            end
            if (sb.size() > 0 && m_valid === 1'b1) begin
                tests++;
                if (m_data !== sb[0].data || m_last !== sb[0].last) begin
                    fails++;
                    $display("FAIL mon_beat t=%0t: data=%h last=%b expected data=%h last=%b",
                             $time, m_data, m_last, sb[0].data, sb[0].last);
                end
            end else if (m_valid === 1'b0) begin
                tests++;
                if (m_data !== '0 || m_last !== 1'b0) begin
                    fails++;
                    $display("FAIL mon_idle t=%0t: data=%h last=%b expected zero", $time, m_data, m_last);
                end
            end
            tests++;
            if ({overflow, tile_done, fifo_full, busy} !== {exp_ovf, exp_td, m_occ == DEPTH, m_occ > 0}) begin
                fails++;
                $display("FAIL mon_flags t=%0t: ovf/td/full/busy=%b%b%b%b expected=%b%b%b%b", $time,
                         overflow, tile_done, fifo_full, busy, exp_ovf, exp_td, m_occ == DEPTH, m_occ > 0);
            end
            if (prev_stall) begin
                tests++;
                if (m_valid !== 1'b1 || m_data !== prev_data) begin
                    fails++;
                    $display("FAIL mon_stall t=%0t: valid=%b data=%h expected valid=1 data=%h",
                             $time, m_valid, m_data, prev_data);
                end
            end
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                beats_seen++;
                if (m_last === 1'b1) lasts_seen++;
            end
            if (reset) begin
                sb.delete();
                row_idx    = 0;
                exp_ovf    = 1'b0;
                exp_td     = 1'b0;
                prev_stall = 1'b0;
            end else begin
                m_hs   = (sb.size() > 0) && (m_ready === 1'b1);
                exp_td = m_hs && sb[0].last;
                if (m_hs) begin
                    m_pop = (sb.size() % BEATS) == 1;
                    void'(sb.pop_front());
                end
                if (row_valid) begin
                    if (m_occ < DEPTH || m_pop) begin
                        for (int k = 0; k < BEATS; k++) begin
                            m_e.data = row_data[k*AXI +: AXI];
                            m_e.last = (k == BEATS - 1) && (row_idx == H - 1);
                            sb.push_back(m_e);
                        end
                        row_idx = (row_idx + 1) % H;
                    end else begin
                        exp_ovf = 1'b1;
                    end
                end
                if (err_clear && !(row_valid && !(m_occ < DEPTH || m_pop))) exp_ovf = 1'b0;
                prev_stall = (m_valid === 1'b1) && (m_ready === 1'b0);
                prev_data  = m_data;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        row_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic rand_row();
        for (int i = 0; i < W; i++) row_data[i*ACC +: ACC] = $urandom;
    endtask

    task automatic drain(input int budget, output bit ok);
        ok = 1'b0;
        m_ready = 1'b1;
        for (int c = 0; c < budget; c++) begin
            tick();
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        tests++;
        if ({m_valid, m_last, fifo_full, overflow, tile_done, busy} !== 6'b0 || m_data !== '0) begin
            fails++;
            $display("FAIL reset_state: v/l/f/o/t/b=%b%b%b%b%b%b data=%h expected all zero",
                     m_valid, m_last, fifo_full, overflow, tile_done, busy, m_data);
        end
        tick();
        reset = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_single_row();
        logic [AXI-1:0] exp0;
        int nv;
        for (int i = 0; i < 4; i++) exp0[i*ACC +: ACC] = ACC'(i + 1);
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < W; i++) row_data[i*ACC +: ACC] = ACC'(i + 1);
        row_valid = 1'b1;
        tick();
        row_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (m_valid !== 1'b1 || m_data !== exp0 || m_last !== 1'b0) begin
            fails++;
            $display("FAIL single_first_beat: valid=%b data=%h last=%b expected 1 %h 0", m_valid, m_data, m_last, exp0);
        end
        nv = 0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (m_valid === 1'b1) nv++;
        end
        @(negedge clk);
        tests++;
        if (nv != 3 || m_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_run: following valid beats=%0d then valid=%b expected 3 then 0", nv, m_valid);
        end
    endtask

    task automatic test_tile();
        int first = -1, nvalid = 0, nlast = 0, last_beat = -1, last_c = -1, ntd = 0, td_c = -1;
        do_reset();
        m_ready = 1'b1;
        fork
            begin
                for (int r = 0; r < H; r++) begin
                    rand_row();
                    row_valid = 1'b1;
                    tick();
                    row_valid = 1'b0;
                    repeat (3) tick();
                end
            end
            begin
                for (int c = 0; c < 72; c++) begin
                    @(negedge clk);
                    if (m_valid === 1'b1) begin
                        if (first < 0) first = c;
                        nvalid++;
                        if (m_last === 1'b1) begin
                            nlast++;
                            last_beat = nvalid - 1;
                            last_c = c;
                        end
                    end
                    if (tile_done === 1'b1) begin
                        ntd++;
                        td_c = c;
                    end
                end
            end
        join
        tests++;
        if (nvalid != 64 || (last_c - first + 1) != 64) begin
            fails++;
            $display("FAIL tile_stream: beats=%0d span=%0d expected 64 64", nvalid, last_c - first + 1);
        end
        tests++;
        if (nlast != 1 || last_beat != 63) begin
            fails++;
            $display("FAIL tile_last: count=%0d at beat %0d expected 1 at 63", nlast, last_beat);
        end
        tests++;
        if (ntd != 1 || td_c != last_c + 1) begin
            fails++;
            $display("FAIL tile_done: pulses=%0d at %0d expected 1 at %0d", ntd, td_c, last_c + 1);
        end
        tests++;
        if (dut.r_row_cnt !== '0) begin
            fails++;
            $display("FAIL tile_rowcnt: got %0d expected 0", dut.r_row_cnt);
        end
    endtask

    task automatic test_overflow();
        int b0;
        bit ok;
        do_reset();
        m_ready = 1'b0;
        for (int r = 0; r < 5; r++) begin
            rand_row();
            row_valid = 1'b1;
            tick();
        end
        row_valid = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        tests++;
        if (fifo_full !== 1'b1 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_state: full=%b overflow=%b expected 1 1", fifo_full, overflow);
        end
        b0 = beats_seen;
        drain(60, ok);
        tests++;
        if (!ok || (beats_seen - b0) != 16) begin
            fails++;
            $display("FAIL ovf_drain: drained=%b beats=%0d expected 1 16", ok, beats_seen - b0);
        end
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        @(negedge clk);
        tests++;
        if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL ovf_clear: overflow=%b expected 0", overflow);
        end
    endtask

    task automatic test_full_accept();
        int b0;
        bit ok;
        do_reset();
        m_ready = 1'b0;
        for (int r = 0; r < 4; r++) begin
            rand_row();
            row_valid = 1'b1;
            tick();
        end
        row_valid = 1'b0;
        tick();
        b0 = beats_seen;
        m_ready = 1'b1;
        repeat (3) tick();
        rand_row();
        row_valid = 1'b1;
        tick();
        row_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (overflow !== 1'b0 || fifo_full !== 1'b1) begin
            fails++;
            $display("FAIL full_accept: overflow=%b full=%b expected 0 1", overflow, fifo_full);
        end
        drain(60, ok);
        tests++;
        if (!ok || (beats_seen - b0) != 20) begin
            fails++;
            $display("FAIL full_accept_drain: drained=%b beats=%0d expected 1 20", ok, beats_seen - b0);
        end
    endtask

    task automatic test_reset_midrow();
        logic [AXI-1:0] exp0;
        bit ok;
        do_reset();
        m_ready = 1'b1;
        rand_row();
        row_valid = 1'b1;
        tick();
        row_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (m_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL midrow_reset: valid=%b busy=%b expected 0 0", m_valid, busy);
        end
        tick();
        rand_row();
        exp0 = row_data[AXI-1:0];
        row_valid = 1'b1;
        tick();
        row_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (m_valid !== 1'b1 || m_data !== exp0 || dut.r_beat_cnt !== '0 || dut.r_row_cnt !== '0) begin
            fails++;
            $display("FAIL midrow_restart: valid=%b data=%h beat=%0d row=%0d expected 1 %h 0 0",
                     m_valid, m_data, dut.r_beat_cnt, dut.r_row_cnt, exp0);
        end
        drain(20, ok);
    endtask

    task automatic test_random_backpressure();
        int l0, sent, cyc;
        bit ok;
        do_reset();
        l0 = lasts_seen;
        sent = 0;
        cyc = 0;
        while (sent < 3 * H && cyc < 3000) begin
            m_ready = ($urandom_range(0, 9) < 6);
            if (!fifo_full && $urandom_range(0, 2) != 0) begin
                rand_row();
                row_valid = 1'b1;
                sent++;
            end else begin
                row_valid = 1'b0;
            end
            tick();
            cyc++;
        end
        row_valid = 1'b0;
        drain(300, ok);
        tests++;
        if (!ok || sent != 3 * H || sb.size() != 0) begin
            fails++;
            $display("FAIL random_drain: drained=%b rows=%0d left=%0d expected 1 %0d 0", ok, sent, sb.size(), 3 * H);
        end
        tests++;
        if ((lasts_seen - l0) != 3 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL random_tiles: m_last=%0d overflow=%b expected 3 0", lasts_seen - l0, overflow);
        end
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_tile();
        test_overflow();
        test_full_accept();
        test_reset_midrow();
        test_random_backpressure();
        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
